// File: rtl/ball_speed_unit.sv
// Per-ball signed X/Y speed registers downstream of hit_unit: ball-ball swap FIFO + FSM,
// wall reflection, shots and pocket clear. Friction stepping is built only with BALL_FRICTION_EN.
module ball_speed_unit #(
  parameter int BALLS           = 4,
  parameter int SPEED_W         = 11,
  parameter int MAX_SPEED       = 511,
  parameter int FIFO_DEPTH      = 4,
  parameter int FRICTION_PERIOD = 4,
  parameter int FRICTION_STEP   = 1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [BALLS-1:0]         balls_collide,
  input  logic [7:0]               Balls_col_ID,
  input  logic [BALLS-1:0]         ballwall_collide,
  input  logic [1:0]               collided_wall,
  input  logic [BALLS-1:0]         balls_in_game,
  input  logic                     shot_valid,
  input  logic [SPEED_W-1:0]       shot_x_speed,
  input  logic [SPEED_W-1:0]       shot_y_speed,
  output logic [BALLS*SPEED_W-1:0] Balls_X_Speed,
  output logic [BALLS*SPEED_W-1:0] Balls_Y_Speed,
  output logic [BALLS-1:0]         balls_moving,
  output logic                     all_stopped,
  output logic                     fifo_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef logic signed [SPEED_W-1:0] speed_t;
`ifdef BALL_FRICTION_EN
  typedef enum logic [1:0] {IDLE, SWAP, FRICTION} state_t;
`else
  typedef enum logic {IDLE, SWAP} state_t;
`endif

  localparam speed_t         MAX_S   = speed_t'(MAX_SPEED);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(FIFO_DEPTH);

  state_t           state_q, state_d;
  speed_t           x_q [BALLS];
  speed_t           y_q [BALLS];
  speed_t           x_d [BALLS];
  speed_t           y_d [BALLS];
  logic [BALLS-1:0] moving_q, moving_d;
  logic             overflow_q;
  logic [3:0]       fifo_a_q [FIFO_DEPTH];
  logic [3:0]       fifo_b_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q, count;
  logic [3:0]       swap_a_q, swap_b_q;
  logic             fifo_empty, fifo_full, push_req, push_ok, pop, shot_ok;

  function automatic speed_t clamp(input speed_t v);
    if (v > MAX_S) return MAX_S;
    if (v < -MAX_S) return -MAX_S;
    return v;
  endfunction

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_P);
  assign push_req   = (|balls_collide) && (Balls_col_ID[3:0] != Balls_col_ID[7:4]);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign shot_ok    = shot_valid && (state_q == IDLE) && all_stopped;

`ifdef BALL_FRICTION_EN
  localparam int              FC_W    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_PERIOD - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam speed_t          STEP_S  = speed_t'(FRICTION_STEP);

  logic [FC_W-1:0] frame_cnt_q;
  logic            friction_pending_q;

  function automatic speed_t fric(input speed_t v);
    if (v > STEP_S) return v - STEP_S;
    if (v < -STEP_S) return v + STEP_S;
    return '0;
  endfunction

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      frame_cnt_q        <= '0;
      friction_pending_q <= 1'b0;
    end else begin
      if (state_q == FRICTION) friction_pending_q <= 1'b0;
      if (startOfFrame) begin
        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_q        <= '0;
          friction_pending_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + FC_ONE;
        end
      end
    end
  end
`else
  localparam int unused_fric_cfg = FRICTION_PERIOD + FRICTION_STEP;
  logic unused_sof;
  assign unused_sof = startOfFrame;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SWAP;
          pop     = 1'b1;
        end
`ifdef BALL_FRICTION_EN
        else if (friction_pending_q) begin
          state_d = FRICTION;
        end
`endif
      end
      SWAP:     state_d = IDLE;
`ifdef BALL_FRICTION_EN
      FRICTION: state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Base update, then wall negate on top of it, then pocket clear wins over everything.
  always_comb begin
    for (int i = 0; i < BALLS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    if (state_q == SWAP) begin
      for (int i = 0; i < BALLS; i++) begin
        for (int j = 0; j < BALLS; j++) begin
          if ((i == int'(swap_a_q) && j == int'(swap_b_q)) ||
              (i == int'(swap_b_q) && j == int'(swap_a_q))) begin
            x_d[i] = x_q[j];
            y_d[i] = y_q[j];
          end
        end
      end
    end
`ifdef BALL_FRICTION_EN
    if (state_q == FRICTION) begin
      for (int i = 0; i < BALLS; i++) begin
        x_d[i] = fric(x_q[i]);
        y_d[i] = fric(y_q[i]);
      end
    end
`endif
    if (shot_ok) begin
      x_d[0] = clamp($signed(shot_x_speed));
      y_d[0] = clamp($signed(shot_y_speed));
    end
    for (int i = 0; i < BALLS; i++) begin
      if (ballwall_collide[i]) begin
        if (collided_wall[0]) x_d[i] = clamp(-x_d[i]);
        if (collided_wall[1]) y_d[i] = clamp(-y_d[i]);
      end
      if (!balls_in_game[i]) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
    end
  end

  always_comb begin
    moving_d = '0;
    for (int i = 0; i < BALLS; i++) moving_d[i] = (x_q[i] != '0) || (y_q[i] != '0);
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      for (int i = 0; i < BALLS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      moving_q <= '0;
    end else begin
      for (int i = 0; i < BALLS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      moving_q <= moving_d;
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      swap_a_q   <= '0;
      swap_b_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        swap_a_q <= fifo_a_q[rd_ptr_q[PTR_W-1:0]];
        swap_b_q <= fifo_b_q[rd_ptr_q[PTR_W-1:0]];
      end
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_a_q[wr_ptr_q[PTR_W-1:0]] <= Balls_col_ID[3:0];
      fifo_b_q[wr_ptr_q[PTR_W-1:0]] <= Balls_col_ID[7:4];
    end
  end

  for (genvar g = 0; g < BALLS; g++) begin : g_out
    assign Balls_X_Speed[g*SPEED_W +: SPEED_W] = x_q[g];
    assign Balls_Y_Speed[g*SPEED_W +: SPEED_W] = y_q[g];
  end

  assign balls_moving  = moving_q;
  assign all_stopped   = ~|moving_q;
  assign fifo_overflow = overflow_q;
endmodule

// File: tb/tb_ball_speed_unit.sv
// Directed self-checking bench for ball_speed_unit (default parameters).
// Friction scenario depends on BALL_FRICTION_EN; without it the speeds must stay untouched.
module tb_ball_speed_unit;
  localparam int BALLS = 4;
  localparam int SW    = 11;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  startOfFrame;
  logic [BALLS-1:0]      balls_collide, ballwall_collide, balls_in_game, balls_moving;
  logic [7:0]            Balls_col_ID;
  logic [1:0]            collided_wall;
  logic                  shot_valid;
  logic [SW-1:0]         shot_x_speed, shot_y_speed;
  logic [BALLS*SW-1:0]   Balls_X_Speed, Balls_Y_Speed;
  logic                  all_stopped, fifo_overflow;
  int                    n_checks = 0;
  int                    n_fail   = 0;

  always #5 clk = ~clk;

  ball_speed_unit dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .balls_collide(balls_collide), .Balls_col_ID(Balls_col_ID),
    .ballwall_collide(ballwall_collide), .collided_wall(collided_wall),
    .balls_in_game(balls_in_game), .shot_valid(shot_valid),
    .shot_x_speed(shot_x_speed), .shot_y_speed(shot_y_speed),
    .Balls_X_Speed(Balls_X_Speed), .Balls_Y_Speed(Balls_Y_Speed),
    .balls_moving(balls_moving), .all_stopped(all_stopped), .fifo_overflow(fifo_overflow)
  );

  function automatic logic signed [SW-1:0] sx(input int i);
    return Balls_X_Speed[i*SW +: SW];
  endfunction
  function automatic logic signed [SW-1:0] sy(input int i);
    return Balls_Y_Speed[i*SW +: SW];
  endfunction

  // Each tick ends 1 time unit after a rising edge: inputs driven here are sampled at the next edge.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_shot(input int x, input int y);
    shot_x_speed = SW'(x); shot_y_speed = SW'(y); shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
  endtask

  task automatic do_wall(input logic [BALLS-1:0] mask, input logic [1:0] code);
    ballwall_collide = mask; collided_wall = code;
    tick();
    ballwall_collide = '0; collided_wall = 2'b00;
  endtask

  task automatic do_collide(input int a, input int b);
    balls_collide = 4'(1 << a) | 4'(1 << b);
    Balls_col_ID  = {4'(b), 4'(a)};
    tick();
    balls_collide = '0; Balls_col_ID = '0;
  endtask

  task automatic clear_all();
    balls_in_game = '0;
    tick();
    balls_in_game = '1;
    tick(2);
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    tick(3);
    resetN = 1'b0;
    tick();
    for (int i = 0; i < BALLS; i++) begin
      n_checks++; if (sx(i) !== 0) begin n_fail++; $display("FAIL reset_x%0d: got %0d expected 0", i, sx(i)); end
      n_checks++; if (sy(i) !== 0) begin n_fail++; $display("FAIL reset_y%0d: got %0d expected 0", i, sy(i)); end
    end
    n_checks++; if (all_stopped !== 1'b1) begin n_fail++; $display("FAIL reset_all_stopped: got %b expected 1", all_stopped); end
    n_checks++; if (balls_moving !== 4'b0000) begin n_fail++; $display("FAIL reset_moving: got %b expected 0000", balls_moving); end
    n_checks++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", fifo_overflow); end
  endtask

  task automatic test_shot_wall();
    do_shot(120, -40);
    n_checks++; if (sx(0) !== 120) begin n_fail++; $display("FAIL shot_x0: got %0d expected 120", sx(0)); end
    n_checks++; if (sy(0) !== -40) begin n_fail++; $display("FAIL shot_y0: got %0d expected -40", sy(0)); end
    n_checks++; if (all_stopped !== 1'b1) begin n_fail++; $display("FAIL stopped_lag: got %b expected 1", all_stopped); end
    tick();
    n_checks++; if (balls_moving !== 4'b0001) begin n_fail++; $display("FAIL moving_after_shot: got %b expected 0001", balls_moving); end
    n_checks++; if (all_stopped !== 1'b0) begin n_fail++; $display("FAIL stopped_after_shot: got %b expected 0", all_stopped); end
    do_wall(4'b0001, 2'b01);
    n_checks++; if (sx(0) !== -120 || sy(0) !== -40) begin n_fail++; $display("FAIL side_wall: got (%0d,%0d) expected (-120,-40)", sx(0), sy(0)); end
    do_wall(4'b0001, 2'b10);
    n_checks++; if (sx(0) !== -120 || sy(0) !== 40) begin n_fail++; $display("FAIL top_wall: got (%0d,%0d) expected (-120,40)", sx(0), sy(0)); end
    do_wall(4'b0001, 2'b11);
    n_checks++; if (sx(0) !== 120 || sy(0) !== -40) begin n_fail++; $display("FAIL corner_wall: got (%0d,%0d) expected (120,-40)", sx(0), sy(0)); end
    do_wall(4'b0010, 2'b11);
    n_checks++; if (sx(0) !== 120 || sy(0) !== -40) begin n_fail++; $display("FAIL wall_mask: got (%0d,%0d) expected (120,-40)", sx(0), sy(0)); end
    do_shot(5, 5);
    n_checks++; if (sx(0) !== 120) begin n_fail++; $display("FAIL shot_while_moving: got %0d expected 120", sx(0)); end
  endtask

  task automatic test_swap();
    clear_all();
    do_shot(50, 0);
    do_collide(0, 1);
    tick(2);
    n_checks++; if (sx(1) !== 50 || sx(0) !== 0) begin n_fail++; $display("FAIL swap_load: got x1=%0d x0=%0d expected 50 0", sx(1), sx(0)); end
    do_collide(1, 2);
    tick();
    n_checks++; if (sx(2) !== 0 || sx(1) !== 50) begin n_fail++; $display("FAIL swap_early: got x1=%0d x2=%0d expected 50 0", sx(1), sx(2)); end
    tick();
    n_checks++; if (sx(1) !== 0 || sy(1) !== 0) begin n_fail++; $display("FAIL swap_ball1: got (%0d,%0d) expected (0,0)", sx(1), sy(1)); end
    n_checks++; if (sx(2) !== 50 || sy(2) !== 0) begin n_fail++; $display("FAIL swap_ball2: got (%0d,%0d) expected (50,0)", sx(2), sy(2)); end
    // wall hit lands in the SWAP cycle, so it negates the freshly swapped value
    do_collide(2, 3);
    tick();
    do_wall(4'b1000, 2'b01);
    n_checks++; if (sx(3) !== -50 || sx(2) !== 0) begin n_fail++; $display("FAIL swap_then_wall: got x3=%0d x2=%0d expected -50 0", sx(3), sx(2)); end
  endtask

  task automatic test_clamp();
    clear_all();
    do_shot(600, -700);
    n_checks++; if (sx(0) !== 511 || sy(0) !== -511) begin n_fail++; $display("FAIL shot_clamp: got (%0d,%0d) expected (511,-511)", sx(0), sy(0)); end
    do_wall(4'b0001, 2'b11);
    n_checks++; if (sx(0) !== -511 || sy(0) !== 511) begin n_fail++; $display("FAIL clamp_negate: got (%0d,%0d) expected (-511,511)", sx(0), sy(0)); end
  endtask

  task automatic test_pocket();
    clear_all();
    do_shot(10, 10);
    do_collide(0, 3);
    tick(2);
    n_checks++; if (sx(3) !== 10 || sy(3) !== 10) begin n_fail++; $display("FAIL pocket_setup: got (%0d,%0d) expected (10,10)", sx(3), sy(3)); end
    tick();
    balls_in_game = 4'b0111;
    do_wall(4'b1000, 2'b11);
    n_checks++; if (sx(3) !== 0 || sy(3) !== 0) begin n_fail++; $display("FAIL pocket_beats_wall: got (%0d,%0d) expected (0,0)", sx(3), sy(3)); end
    balls_in_game = 4'b1111;
    tick();
  endtask

  task automatic test_shot_after_stop();
    clear_all();
    do_shot(7, 7);
    tick();
    balls_in_game = 4'b1110;
    tick();
    balls_in_game = 4'b1111;
    n_checks++; if (sx(0) !== 0) begin n_fail++; $display("FAIL pocket_ball0: got %0d expected 0", sx(0)); end
    do_shot(9, 9);
    n_checks++; if (sx(0) !== 0) begin n_fail++; $display("FAIL shot_blocked_lag: got %0d expected 0", sx(0)); end
    do_shot(9, 9);
    n_checks++; if (sx(0) !== 9 || sy(0) !== 9) begin n_fail++; $display("FAIL shot_after_stop: got (%0d,%0d) expected (9,9)", sx(0), sy(0)); end
  endtask

  task automatic test_overflow();
    int pa[6] = '{0, 0, 0, 1, 1, 2};
    int pb[6] = '{1, 2, 3, 2, 3, 3};
    clear_all();
    balls_collide = 4'b0100; Balls_col_ID = {4'd2, 4'd2};
    tick(10);
    balls_collide = 4'b0000; Balls_col_ID = {4'd2, 4'd1};
    tick(10);
    Balls_col_ID = '0;
    n_checks++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL ignored_events: got %b expected 0", fifo_overflow); end
    tick(4);
    for (int k = 0; k < 11; k++) begin
      balls_collide = 4'(1 << pa[k % 6]) | 4'(1 << pb[k % 6]);
      Balls_col_ID  = {4'(pb[k % 6]), 4'(pa[k % 6])};
      tick();
      if (k == 4) begin
        n_checks++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_after5: got %b expected 0", fifo_overflow); end
      end
      if (k == 7) begin
        n_checks++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_frees: got %b expected 0", fifo_overflow); end
      end
      if (k == 8) begin
        n_checks++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", fifo_overflow); end
      end
    end
    balls_collide = '0; Balls_col_ID = '0;
    tick(30);
    n_checks++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", fifo_overflow); end
  endtask

  task automatic test_friction();
    clear_all();
    do_shot(3, -1);
    frame_pulse(); frame_pulse(); frame_pulse();
    n_checks++; if (sx(0) !== 3 || sy(0) !== -1) begin n_fail++; $display("FAIL fric_before_wrap: got (%0d,%0d) expected (3,-1)", sx(0), sy(0)); end
    frame_pulse();
`ifdef BALL_FRICTION_EN
    n_checks++; if (sx(0) !== 2 || sy(0) !== 0) begin n_fail++; $display("FAIL fric_step1: got (%0d,%0d) expected (2,0)", sx(0), sy(0)); end
    repeat (4) frame_pulse();
    n_checks++; if (sx(0) !== 1 || sy(0) !== 0) begin n_fail++; $display("FAIL fric_step2: got (%0d,%0d) expected (1,0)", sx(0), sy(0)); end
    repeat (4) frame_pulse();
    n_checks++; if (sx(0) !== 0 || sy(0) !== 0) begin n_fail++; $display("FAIL fric_step3: got (%0d,%0d) expected (0,0)", sx(0), sy(0)); end
    tick();
    n_checks++; if (all_stopped !== 1'b1) begin n_fail++; $display("FAIL fric_stopped: got %b expected 1", all_stopped); end
`else
    n_checks++; if (sx(0) !== 3 || sy(0) !== -1) begin n_fail++; $display("FAIL no_friction: got (%0d,%0d) expected (3,-1)", sx(0), sy(0)); end
`endif
  endtask

  task automatic test_reset_mid_swap();
    clear_all();
    do_shot(25, 25);
    do_collide(0, 1);
    tick();
    resetN = 1'b1;
    #1;
    n_checks++; if (sx(0) !== 0 || fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset: got x0=%0d ovf=%b expected 0 0", sx(0), fifo_overflow); end
    tick(2);
    resetN = 1'b0;
    tick(3);
    n_checks++; if (sx(1) !== 0 || sy(1) !== 0) begin n_fail++; $display("FAIL reset_abort_swap: got (%0d,%0d) expected (0,0)", sx(1), sy(1)); end
    n_checks++; if (all_stopped !== 1'b1) begin n_fail++; $display("FAIL reset_abort_stopped: got %b expected 1", all_stopped); end
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; balls_collide = '0; Balls_col_ID = '0;
    ballwall_collide = '0; collided_wall = 2'b00; balls_in_game = '1;
    shot_valid = 1'b0; shot_x_speed = '0; shot_y_speed = '0;
    test_reset();
    test_shot_wall();
    test_swap();
    test_clamp();
    test_pocket();
    test_shot_after_stop();
    test_overflow();
    test_friction();
    test_reset_mid_swap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end
endmodule
